// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues single-cycle-latency reads
// to instruction memory and hands {pc, instr} to decode through a small FIFO.
module imem_fetch_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter int                PC_STEP   = 4,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic              halted,
    output logic              align_err
);

    localparam int                PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int                CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   pc_r;
    logic                started_r;
    logic                inflight_r;
    logic [ADDR_W-1:0]   inflight_pc_r;
    logic                inflight_epoch_r;
    logic                epoch_r;
    logic                align_err_r;

    logic [ADDR_W-1:0]   fifo_pc_r    [BUF_DEPTH];
    logic [DATA_W-1:0]   fifo_instr_r [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;

    logic                pop_s;
    logic                push_s;
    logic                issue_s;
    logic                misaligned_s;
    logic [CNT_W:0]      occupancy_s;

    // Handshake, issue and push decisions for the current cycle
    always_comb begin
        pop_s        = (count_r != {CNT_W{1'b0}}) & out_ready;
        misaligned_s = redirect_valid & (redirect_pc[1:0] != 2'b00);
        // Slots already claimed once this cycle's pop is accounted for
        occupancy_s  = {1'b0, count_r} + (CNT_W + 1)'(inflight_r) - (CNT_W + 1)'(pop_s);
        issue_s      = started_r & (state_r == ST_RUN) & ~redirect_valid & (occupancy_s < DEPTH_C);
        push_s       = inflight_r & (inflight_epoch_r == epoch_r) & ~redirect_valid;
    end

    // Next-state logic; a redirect overrides halt and drain
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_valid) begin
            if (misaligned_s) begin
                state_nxt_s = ST_HALTED;
            end else begin
                state_nxt_s = ST_RUN;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt_req) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!inflight_r) begin
                        state_nxt_s = ST_HALTED;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                ST_HALTED: state_nxt_s = ST_HALTED;
                default:   state_nxt_s = ST_HALTED;
            endcase
        end
    end

    // Control state, fetch PC and in-flight request tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_RUN;
            pc_r             <= RESET_PC;
            started_r        <= 1'b0;
            inflight_r       <= 1'b0;
            inflight_pc_r    <= {ADDR_W{1'b0}};
            inflight_epoch_r <= 1'b0;
            epoch_r          <= 1'b0;
            align_err_r      <= 1'b0;
        end else begin
            started_r        <= 1'b1;
            state_r          <= state_nxt_s;
            inflight_r       <= issue_s;
            inflight_pc_r    <= issue_s ? pc_r : inflight_pc_r;
            inflight_epoch_r <= issue_s ? epoch_r : inflight_epoch_r;
            if (redirect_valid) begin
                epoch_r <= ~epoch_r;
                if (misaligned_s) begin
                    align_err_r <= 1'b1;
                end else begin
                    pc_r <= redirect_pc;
                end
            end else if (issue_s) begin
                pc_r <= pc_r + STEP_C;
            end
        end
    end

    // Output FIFO; a redirect flushes after any same-cycle pop has been taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_pc_r[i]    <= {ADDR_W{1'b0}};
                fifo_instr_r[i] <= {DATA_W{1'b0}};
            end
        end else if (redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]    <= inflight_pc_r;
                fifo_instr_r[wr_ptr_r] <= imem_data;
                wr_ptr_r               <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Output drive; the head is zeroed while the FIFO is empty
    always_comb begin
        imem_rd_en = issue_s;
        imem_addr  = pc_r;
        out_valid  = (count_r != {CNT_W{1'b0}});
        halted     = (state_r == ST_HALTED);
        align_err  = align_err_r;
        if (out_valid) begin
            out_pc    = fifo_pc_r[rd_ptr_r];
            out_instr = fifo_instr_r[rd_ptr_r];
        end else begin
            out_pc    = {ADDR_W{1'b0}};
            out_instr = {DATA_W{1'b0}};
        end
    end

endmodule
